// File: rtl/instr_assembly_register_if.sv
// ---------------------------------------------------------------------------
// instr_assembly_register_if
//   Bundles the beat input side and the decoder side of the instruction
//   assembly register.
//   master : memory/decoder side (drives I, Write, Flush, IRTake)
//   slave  : the assembly register itself
//   Signals:
//     I          beat data (BUS_W)
//     Write      beat valid
//     WriteReady beat can be accepted this cycle
//     Flush      discard partial and queued instructions
//     IROut      head instruction, 0 when empty (BUS_W*BEATS)
//     IRValid    queue non-empty
//     IRTake     decoder consumes head
//     Count      queued complete instructions
//     BeatCnt    beats of the current partial instruction
// ---------------------------------------------------------------------------
interface instr_assembly_register_if #(
  parameter int BUS_W = 8,
  parameter int BEATS = 2,
  parameter int DEPTH = 2
);
  localparam int INSTR_W = BUS_W * BEATS;
  localparam int CW      = $clog2(DEPTH + 1);
  localparam int BW      = $clog2(BEATS);

  logic [BUS_W-1:0]   I;
  logic               Write;
  logic               WriteReady;
  logic               Flush;
  logic [INSTR_W-1:0] IROut;
  logic               IRValid;
  logic               IRTake;
  logic [CW-1:0]      Count;
  logic [BW-1:0]      BeatCnt;

  modport master (
    output I, Write, Flush, IRTake,
    input  WriteReady, IROut, IRValid, Count, BeatCnt
  );

  modport slave (
    input  I, Write, Flush, IRTake,
    output WriteReady, IROut, IRValid, Count, BeatCnt
  );
endinterface

// File: rtl/instr_assembly_register.sv
// ---------------------------------------------------------------------------
// instr_assembly_register
//   Assembles BEATS consecutive BUS_W-wide beats into one instruction and
//   queues up to DEPTH complete instructions for the decoder. Beat position
//   comes from an internal beat counter; LSB_FIRST selects whether the first
//   beat lands in the low or the high slice.
//   Ports:
//     Clock  rising-edge clock
//     Reset  synchronous, active-high; clears everything
//     bus    instr_assembly_register_if.slave (beat input, decoder output)
//   The interface instance must use the same BUS_W/BEATS/DEPTH values.
// ---------------------------------------------------------------------------
module instr_assembly_register #(
  parameter int BUS_W     = 8,
  parameter int BEATS     = 2,
  parameter int DEPTH     = 2,
  parameter int LSB_FIRST = 1
) (
  input  logic                          Clock,
  input  logic                          Reset,
  instr_assembly_register_if.slave      bus
);
  localparam int INSTR_W = BUS_W * BEATS;
  localparam int CW      = $clog2(DEPTH + 1);
  localparam int BW      = $clog2(BEATS);
  localparam int PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
  localparam logic [PW-1:0] LAST_PTR  = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);

  logic [INSTR_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]      head_q, head_d;
  logic [PW-1:0]      tail_q, tail_d;
  logic [CW-1:0]      count_q, count_d;
  logic [BW-1:0]      beat_q, beat_d;
  logic [INSTR_W-1:0] asm_q, asm_d;
  logic [INSTR_W-1:0] asm_merged;
  logic [BW-1:0]      slice_idx;
  logic               pop_req, final_beat, write_ready, accept, push, pop;

  always_comb begin
    pop_req     = bus.IRTake && (count_q != '0);
    final_beat  = (beat_q == LAST_BEAT);
    // Only the final beat can be refused: it needs a free queue slot, which
    // a same-cycle pop also provides.
    write_ready = !bus.Flush && !Reset &&
                  (!final_beat || (count_q < FULL_CNT) || pop_req);
    accept      = bus.Write && write_ready;
    push        = accept && final_beat;
    pop         = pop_req && !bus.Flush;
    slice_idx   = (LSB_FIRST != 0) ? beat_q : (LAST_BEAT - beat_q);
  end

  // Assembly register with the current beat dropped into its slice; this is
  // also the value pushed on the final beat.
  generate
    for (genvar gi = 0; gi < BEATS; gi++) begin : g_slice
      assign asm_merged[gi*BUS_W +: BUS_W] =
        (slice_idx == BW'(gi)) ? bus.I : asm_q[gi*BUS_W +: BUS_W];
    end
  endgenerate

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    beat_d  = beat_q;
    asm_d   = asm_q;
    if (accept) begin
      if (final_beat) begin
        beat_d = '0;
        asm_d  = '0;
        tail_d = (tail_q == LAST_PTR) ? '0 : tail_q + 1'b1;
      end else begin
        beat_d = beat_q + 1'b1;
        asm_d  = asm_merged;
      end
    end
    if (pop) begin
      head_d = (head_q == LAST_PTR) ? '0 : head_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset || bus.Flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      beat_q  <= '0;
      asm_q   <= '0;
      for (int e = 0; e < DEPTH; e++) begin
        mem_q[e] <= '0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      beat_q  <= beat_d;
      asm_q   <= asm_d;
      for (int e = 0; e < DEPTH; e++) begin
        if (push && (tail_q == PW'(e))) begin
          mem_q[e] <= asm_merged;
        end
      end
    end
  end

  assign bus.WriteReady = write_ready;
  assign bus.IRValid    = (count_q != '0);
  assign bus.IROut      = (count_q != '0) ? mem_q[head_q] : '0;
  assign bus.Count      = count_q;
  assign bus.BeatCnt    = beat_q;

endmodule

// File: tb/tb_instr_assembly_register.sv
// ---------------------------------------------------------------------------
// tb_instr_assembly_register
//   Three instances share one stimulus stream:
//     dut0: BEATS=2 DEPTH=2 LSB_FIRST=1
//     dut1: BEATS=2 DEPTH=2 LSB_FIRST=0
//     dut2: BEATS=4 DEPTH=3 LSB_FIRST=0
//   Each has a reference model built from a queue of finished instructions
//   and a list of beats collected so far.
// ---------------------------------------------------------------------------
module tb_instr_assembly_register;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] t_data = 8'h00;
  logic       t_w = 1'b0;
  logic       t_fl = 1'b0;
  logic       t_tk = 1'b0;

  always #5 clk = ~clk;

  instr_assembly_register_if #(.BUS_W(8), .BEATS(2), .DEPTH(2)) bus0 ();
  instr_assembly_register_if #(.BUS_W(8), .BEATS(2), .DEPTH(2)) bus1 ();
  instr_assembly_register_if #(.BUS_W(8), .BEATS(4), .DEPTH(3)) bus2 ();

  assign bus0.I = t_data; assign bus0.Write = t_w; assign bus0.Flush = t_fl; assign bus0.IRTake = t_tk;
  assign bus1.I = t_data; assign bus1.Write = t_w; assign bus1.Flush = t_fl; assign bus1.IRTake = t_tk;
  assign bus2.I = t_data; assign bus2.Write = t_w; assign bus2.Flush = t_fl; assign bus2.IRTake = t_tk;

  instr_assembly_register #(.BUS_W(8), .BEATS(2), .DEPTH(2), .LSB_FIRST(1)) dut0 (
    .Clock(clk), .Reset(rst), .bus(bus0));
  instr_assembly_register #(.BUS_W(8), .BEATS(2), .DEPTH(2), .LSB_FIRST(0)) dut1 (
    .Clock(clk), .Reset(rst), .bus(bus1));
  instr_assembly_register #(.BUS_W(8), .BEATS(4), .DEPTH(3), .LSB_FIRST(0)) dut2 (
    .Clock(clk), .Reset(rst), .bus(bus2));

  wire [2:0] d_ready = {bus2.WriteReady, bus1.WriteReady, bus0.WriteReady};
  wire [2:0] d_valid = {bus2.IRValid, bus1.IRValid, bus0.IRValid};
  logic [31:0] d_out [3];
  int          d_cnt [3];
  int          d_beat [3];
  always_comb begin
    d_out[0]  = 32'(bus0.IROut);
    d_out[1]  = 32'(bus1.IROut);
    d_out[2]  = bus2.IROut;
    d_cnt[0]  = 32'(bus0.Count);
    d_cnt[1]  = 32'(bus1.Count);
    d_cnt[2]  = 32'(bus2.Count);
    d_beat[0] = 32'(bus0.BeatCnt);
    d_beat[1] = 32'(bus1.BeatCnt);
    d_beat[2] = 32'(bus2.BeatCnt);
  end

  // Reference model state
  int          NB [3] = '{2, 2, 4};
  int          ND [3] = '{2, 2, 3};
  bit          LSB[3] = '{1'b1, 1'b0, 1'b0};
  logic [31:0] mq   [3][$];
  logic [7:0]  part [3][$];
  bit          mready [3];

  int n_cmp  = 0;
  int n_fail = 0;
  int txn    = 0;

  // Apply inputs for the coming edge and check the combinational ready.
  task automatic drive(input logic w, input logic [7:0] data, input logic fl,
                       input logic tk, input logic rs);
    t_w = w; t_data = data; t_fl = fl; t_tk = tk; rst = rs;
    for (int d = 0; d < 3; d++) begin
      mready[d] = !rs && !fl &&
                  ((part[d].size() != NB[d] - 1) || (mq[d].size() < ND[d]) ||
                   (tk && (mq[d].size() > 0)));
    end
    #1;
    for (int d = 0; d < 3; d++) begin
      n_cmp++;
      if (d_ready[d] !== mready[d]) begin
        n_fail++;
        $display("FAIL ready dut%0d: got %b expected %b", d, d_ready[d], mready[d]);
      end
    end
  endtask

  // Advance one clock, update the models, and compare registered outputs.
  task automatic tick();
    for (int d = 0; d < 3; d++) begin
      if (rst || t_fl) begin
        mq[d].delete();
        part[d].delete();
      end else begin
        if (t_tk && (mq[d].size() > 0)) void'(mq[d].pop_front());
        if (t_w && mready[d]) begin
          part[d].push_back(t_data);
          if (part[d].size() == NB[d]) begin
            logic [31:0] v;
            v = '0;
            for (int k = 0; k < NB[d]; k++) begin
              int sh;
              sh = LSB[d] ? k : NB[d] - 1 - k;
              v = v | (32'(part[d][k]) << (8 * sh));
            end
            mq[d].push_back(v);
            part[d].delete();
          end
        end
      end
    end
    @(posedge clk);
    #1;
    txn++;
    $display("txn %0d: W=%b I=%02h F=%b T=%b R=%b rdy=%b%b%b cnt=%0d/%0d/%0d",
             txn, t_w, t_data, t_fl, t_tk, rst, mready[0], mready[1], mready[2],
             mq[0].size(), mq[1].size(), mq[2].size());
    for (int d = 0; d < 3; d++) begin
      logic [31:0] exp_out;
      exp_out = (mq[d].size() > 0) ? mq[d][0] : 32'h0;
      n_cmp++;
      if (d_valid[d] !== (mq[d].size() > 0)) begin
        n_fail++;
        $display("FAIL irvalid dut%0d: got %b expected %b", d, d_valid[d], mq[d].size() > 0);
      end
      n_cmp++;
      if (d_out[d] !== exp_out) begin
        n_fail++;
        $display("FAIL irout dut%0d: got %h expected %h", d, d_out[d], exp_out);
      end
      n_cmp++;
      if (d_cnt[d] !== mq[d].size()) begin
        n_fail++;
        $display("FAIL count dut%0d: got %0d expected %0d", d, d_cnt[d], mq[d].size());
      end
      n_cmp++;
      if (d_beat[d] !== part[d].size()) begin
        n_fail++;
        $display("FAIL beatcnt dut%0d: got %0d expected %0d", d, d_beat[d], part[d].size());
      end
    end
  endtask

  task automatic do_reset();
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    tick();
  endtask

  task automatic test_reset();
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    n_cmp++;
    if (bus0.WriteReady !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ready: got %b expected 0", bus0.WriteReady);
    end
    tick();
    n_cmp++;
    if (bus0.IRValid !== 1'b0 || bus0.IROut !== 16'h0 || bus0.Count !== 2'd0 || bus0.BeatCnt !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: got valid=%b out=%h cnt=%0d beat=%0d expected all 0",
               bus0.IRValid, bus0.IROut, bus0.Count, bus0.BeatCnt);
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (bus0.WriteReady !== 1'b1) begin
      n_fail++;
      $display("FAIL idle_ready: got %b expected 1", bus0.WriteReady);
    end
  endtask

  task automatic test_assemble();
    drive(1'b1, 8'h34, 1'b0, 1'b0, 1'b0); tick();
    drive(1'b1, 8'h12, 1'b0, 1'b0, 1'b0); tick();
    n_cmp++;
    if (bus0.IRValid !== 1'b1 || bus0.IROut !== 16'h1234 || bus0.Count !== 2'd1 || bus0.BeatCnt !== 1'b0) begin
      n_fail++;
      $display("FAIL assemble: got valid=%b out=%h cnt=%0d beat=%0d expected 1/1234/1/0",
               bus0.IRValid, bus0.IROut, bus0.Count, bus0.BeatCnt);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] beats [5];
    beats = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, beats[i], 1'b0, 1'b0, 1'b0);
      tick();
    end
    n_cmp++;
    if (bus0.Count !== 2'd2 || bus0.IROut !== 16'h2211 || bus0.BeatCnt !== 1'b1) begin
      n_fail++;
      $display("FAIL full_state: got cnt=%0d out=%h beat=%0d expected 2/2211/1",
               bus0.Count, bus0.IROut, bus0.BeatCnt);
    end
    drive(1'b1, 8'h66, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (bus0.WriteReady !== 1'b0) begin
      n_fail++;
      $display("FAIL full_backpressure: got %b expected 0", bus0.WriteReady);
    end
    drive(1'b1, 8'h66, 1'b0, 1'b1, 1'b0);
    n_cmp++;
    if (bus0.WriteReady !== 1'b1) begin
      n_fail++;
      $display("FAIL take_releases: got %b expected 1", bus0.WriteReady);
    end
  endtask

  task automatic test_push_pop_full();
    tick();
    n_cmp++;
    if (bus0.Count !== 2'd2 || bus0.IROut !== 16'h4433) begin
      n_fail++;
      $display("FAIL push_pop: got cnt=%0d out=%h expected 2/4433", bus0.Count, bus0.IROut);
    end
    drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0); tick();
    n_cmp++;
    if (bus0.Count !== 2'd1 || bus0.IROut !== 16'h6655) begin
      n_fail++;
      $display("FAIL pop_order: got cnt=%0d out=%h expected 1/6655", bus0.Count, bus0.IROut);
    end
  endtask

  task automatic test_flush();
    drive(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0); tick();
    n_cmp++;
    if (bus0.BeatCnt !== 1'b1) begin
      n_fail++;
      $display("FAIL partial_beat: got %0d expected 1", bus0.BeatCnt);
    end
    drive(1'b1, 8'h99, 1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (bus0.WriteReady !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_ready: got %b expected 0", bus0.WriteReady);
    end
    tick();
    n_cmp++;
    if (bus0.Count !== 2'd0 || bus0.IRValid !== 1'b0 || bus0.BeatCnt !== 1'b0 || bus0.IROut !== 16'h0) begin
      n_fail++;
      $display("FAIL flush_state: got cnt=%0d valid=%b beat=%0d out=%h expected all 0",
               bus0.Count, bus0.IRValid, bus0.BeatCnt, bus0.IROut);
    end
    drive(1'b1, 8'hCD, 1'b0, 1'b0, 1'b0); tick();
    drive(1'b1, 8'hAB, 1'b0, 1'b0, 1'b0); tick();
    n_cmp++;
    if (bus0.IROut !== 16'hABCD) begin
      n_fail++;
      $display("FAIL after_flush: got %h expected abcd", bus0.IROut);
    end
  endtask

  task automatic test_params();
    do_reset();
    drive(1'b1, 8'h12, 1'b0, 1'b0, 1'b0); tick();
    drive(1'b1, 8'h34, 1'b0, 1'b0, 1'b0); tick();
    n_cmp++;
    if (bus1.IROut !== 16'h1234) begin
      n_fail++;
      $display("FAIL msb_first: got %h expected 1234", bus1.IROut);
    end
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
      tick();
    end
    n_cmp++;
    if (bus2.IROut !== 32'h01020304 || bus2.Count !== 2'd1) begin
      n_fail++;
      $display("FAIL four_beats: got out=%h cnt=%0d expected 01020304/1", bus2.IROut, bus2.Count);
    end
  endtask

  task automatic test_reset_midway();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
      tick();
    end
    drive(1'b1, 8'h77, 1'b0, 1'b0, 1'b1);
    n_cmp++;
    if (d_ready !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_blocks_write: got %b expected 000", d_ready);
    end
    tick();
    n_cmp++;
    if (bus0.IRValid !== 1'b0 || bus0.IROut !== 16'h0 || bus0.Count !== 2'd0 || bus0.BeatCnt !== 1'b0) begin
      n_fail++;
      $display("FAIL midway_reset: got valid=%b out=%h cnt=%0d beat=%0d expected all 0",
               bus0.IRValid, bus0.IROut, bus0.Count, bus0.BeatCnt);
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (d_ready !== 3'b111) begin
      n_fail++;
      $display("FAIL ready_after_reset: got %b expected 111", d_ready);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      drive($urandom_range(0, 3) != 0, 8'($urandom),
            $urandom_range(0, 39) == 0, $urandom_range(0, 9) < 4,
            $urandom_range(0, 59) == 0);
      tick();
    end
  endtask

  initial begin
    @(posedge clk);
    #1;
    test_reset();
    test_assemble();
    test_backpressure();
    test_push_pop_full();
    test_flush();
    test_params();
    test_reset_midway();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
